// File: rtl/ls259_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ls259_ctrl_pkg
//  Description : Shared types and helpers for the LS259 write scheduler:
//                command opcodes, controller states, latch width and a
//                lowest-set-bit priority encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package ls259_ctrl_pkg;

  localparam int LATCH_W = 8;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_BIT   = 2'b01,
    OP_BYTE  = 2'b10,
    OP_CLEAR = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WRITE = 2'b01,
    ST_CLEAR = 2'b10
  } state_t;

  // Index of the lowest set bit; returns 0 for an all-zero vector.
  function automatic logic [2:0] lsb_index(input logic [LATCH_W-1:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = LATCH_W - 1; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin arbiter. Search begins one past the last
//                granted requester and wraps; the pointer moves only when
//                the grant is actually taken (advance).
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic                       clk,
  input  logic                       rst_b,
  input  logic [N_REQ-1:0]           valid,
  input  logic                       advance,
  output logic [N_REQ-1:0]           grant,
  output logic [$clog2(N_REQ)-1:0]   grant_idx
);

  localparam int IDX_W = $clog2(N_REQ);

  logic [IDX_W-1:0] last_q;
  logic [IDX_W-1:0] last_d;
  logic             w_found;
  int               w_idx;

  // Nearest valid requester after the last winner gets a one-hot grant.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_idx     = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = int'(last_q) + k;
      if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
      if (!w_found && valid[IDX_W'(w_idx)]) begin
        w_found                = 1'b1;
        grant[IDX_W'(w_idx)]   = 1'b1;
        grant_idx              = IDX_W'(w_idx);
      end
    end
    last_d = advance ? grant_idx : last_q;
  end

  // Pointer resets to the highest index so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) last_q <= IDX_W'(N_REQ - 1);
    else        last_q <= last_d;
  end

endmodule
`default_nettype wire

// File: rtl/ls259_write_sched.sv
`default_nettype none
// ============================================================================
//  Module      : ls259_write_sched
//  Description : Arbitrates byte/bit/clear commands from several requesters
//                and turns each into the minimal run of single-bit LS259
//                strobes (or one clear pulse), tracking the latch contents
//                in a shadow register to skip bits that would not change.
//  Revision    : 1.0 - initial release
// ============================================================================
module ls259_write_sched
  import ls259_ctrl_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic                       clk,
  input  logic                       rst_b,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [2*N_REQ-1:0]         req_op,
  input  logic [3*N_REQ-1:0]         req_sel,
  input  logic [8*N_REQ-1:0]         req_data,
  output logic [2:0]                 latch_s,
  output logic                       latch_d,
  output logic                       latch_en_b,
  output logic                       latch_clr_b,
  output logic [LATCH_W-1:0]         shadow_q,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   grant_id
);

  localparam int IDX_W = $clog2(N_REQ);

  state_t             state_q, state_d;
  logic [LATCH_W-1:0] pending_q, pending_d;
  logic [LATCH_W-1:0] target_q, target_d;
  logic [LATCH_W-1:0] shadow_d;
  logic [2:0]         latch_s_q, latch_s_d;
  logic               latch_d_q, latch_d_d;
  logic               en_b_q, en_b_d;
  logic               clr_b_q, clr_b_d;
  logic               busy_q, busy_d;
  logic [IDX_W-1:0]   grant_id_q, grant_id_d;

  logic [N_REQ-1:0]   w_arb_valid;
  logic [N_REQ-1:0]   w_grant;
  logic [IDX_W-1:0]   w_grant_idx;
  logic               w_accept;
  logic [1:0]         w_sel_op;
  logic [2:0]         w_sel_sel;
  logic [7:0]         w_sel_data;
  logic [LATCH_W-1:0] w_new_pending;
  logic [LATCH_W-1:0] w_new_target;
  logic [LATCH_W-1:0] w_issue_src;
  logic [LATCH_W-1:0] w_issue_tgt;
  logic [2:0]         w_issue_idx;

  // Only the idle controller offers grants; ready is the grant itself.
  assign w_arb_valid = req_valid & {N_REQ{state_q == ST_IDLE}};
  assign w_accept    = |w_grant;
  assign req_ready   = w_grant;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .clk       (clk),
    .rst_b     (rst_b),
    .valid     (w_arb_valid),
    .advance   (w_accept),
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  // Pick the granted requester's command fields (grant is one-hot or zero).
  always_comb begin
    w_sel_op   = '0;
    w_sel_sel  = '0;
    w_sel_data = '0;
    for (int r = 0; r < N_REQ; r++) begin
      if (w_grant[r]) begin
        w_sel_op   = w_sel_op   | req_op[2*r +: 2];
        w_sel_sel  = w_sel_sel  | req_sel[3*r +: 3];
        w_sel_data = w_sel_data | req_data[8*r +: 8];
      end
    end
  end

  // Next-state logic: decode accepted commands, issue one strobe per cycle.
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    target_d      = target_q;
    latch_s_d     = latch_s_q;
    latch_d_d     = latch_d_q;
    en_b_d        = 1'b1;
    clr_b_d       = 1'b1;
    busy_d        = 1'b0;
    grant_id_d    = grant_id_q;
    w_new_pending = '0;
    w_new_target  = target_q;
    w_issue_src   = '0;
    w_issue_tgt   = target_q;
    w_issue_idx   = '0;

    // The shadow follows whatever the latch captures at this edge.
    shadow_d = shadow_q;
    if (!clr_b_q)     shadow_d = '0;
    else if (!en_b_q) shadow_d[latch_s_q] = latch_d_q;

    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          grant_id_d = w_grant_idx;
          case (op_t'(w_sel_op))
            OP_BIT: begin
              w_new_target[w_sel_sel] = w_sel_data[0];
              if (w_sel_data[0] != shadow_q[w_sel_sel])
                w_new_pending = LATCH_W'(1) << w_sel_sel;
            end
            OP_BYTE: begin
              w_new_target  = w_sel_data;
              w_new_pending = w_sel_data ^ shadow_q;
            end
            OP_CLEAR: begin
              clr_b_d = 1'b0;
              busy_d  = 1'b1;
              state_d = ST_CLEAR;
            end
            default: ;
          endcase
          target_d = w_new_target;
          if (w_new_pending != '0) state_d = ST_WRITE;
        end
        // The first strobe is loaded at the accept edge so it shows at T+1.
        w_issue_src = w_new_pending;
        w_issue_tgt = w_new_target;
      end
      ST_WRITE: begin
        if (pending_q == '0) state_d = ST_IDLE;
        w_issue_src = pending_q;
        w_issue_tgt = target_q;
      end
      ST_CLEAR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (w_issue_src != '0) begin
      w_issue_idx = lsb_index(w_issue_src);
      latch_s_d   = w_issue_idx;
      latch_d_d   = w_issue_tgt[w_issue_idx];
      en_b_d      = 1'b0;
      busy_d      = 1'b1;
      pending_d   = w_issue_src & ~(LATCH_W'(1) << w_issue_idx);
    end
  end

  // Controller state and registered latch outputs; reset clears the latch.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= ST_IDLE;
      pending_q  <= '0;
      target_q   <= '0;
      shadow_q   <= '0;
      latch_s_q  <= '0;
      latch_d_q  <= 1'b0;
      en_b_q     <= 1'b1;
      clr_b_q    <= 1'b0;
      busy_q     <= 1'b0;
      grant_id_q <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      target_q   <= target_d;
      shadow_q   <= shadow_d;
      latch_s_q  <= latch_s_d;
      latch_d_q  <= latch_d_d;
      en_b_q     <= en_b_d;
      clr_b_q    <= clr_b_d;
      busy_q     <= busy_d;
      grant_id_q <= grant_id_d;
    end
  end

  assign latch_s     = latch_s_q;
  assign latch_d     = latch_d_q;
  assign latch_en_b  = en_b_q;
  assign latch_clr_b = clr_b_q;
  assign busy        = busy_q;
  assign grant_id    = grant_id_q;

endmodule
`default_nettype wire

// File: tb/tb_ls259_write_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ls259_write_sched
//  Description : Random-command bench for ls259_write_sched with a queue-based
//                reference of the latch strobe stream and shadow contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ls259_write_sched;

  localparam int N_REQ = 3;
  localparam int GW    = $clog2(N_REQ);
  localparam int NCYC  = 4000;

  logic                 clk = 1'b0;
  logic                 rst_b;
  logic [N_REQ-1:0]     req_valid;
  logic [N_REQ-1:0]     req_ready;
  logic [2*N_REQ-1:0]   req_op;
  logic [3*N_REQ-1:0]   req_sel;
  logic [8*N_REQ-1:0]   req_data;
  logic [2:0]           latch_s;
  logic                 latch_d;
  logic                 latch_en_b;
  logic                 latch_clr_b;
  logic [7:0]           shadow_q;
  logic                 busy;
  logic [GW-1:0]        grant_id;

  ls259_write_sched #(.N_REQ(N_REQ)) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_sel     (req_sel),
    .req_data    (req_data),
    .latch_s     (latch_s),
    .latch_d     (latch_d),
    .latch_en_b  (latch_en_b),
    .latch_clr_b (latch_clr_b),
    .shadow_q    (shadow_q),
    .busy        (busy),
    .grant_id    (grant_id)
  );

  always #5 clk = ~clk;

  // Expected latch activity: one entry per strobe cycle, oldest first.
  typedef struct {
    bit       clr;
    bit [2:0] s;
    bit       d;
  } item_t;

  item_t          q[$];
  bit [7:0]       m_shadow;
  int             m_last;
  int             m_grant;
  bit [2:0]       m_s;
  bit             m_d;
  bit             m_rst_clr;
  bit [N_REQ-1:0] acc;
  int             n_vec = 0;
  int             n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_shadow  = 8'h00;
    m_last    = N_REQ - 1;
    m_grant   = 0;
    m_s       = 3'd0;
    m_d       = 1'b0;
    m_rst_clr = 1'b1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_en_b",   32'(latch_en_b),  32'd1);
    chk("rst_clr_b",  32'(latch_clr_b), 32'd0);
    chk("rst_s",      32'(latch_s),     32'd0);
    chk("rst_d",      32'(latch_d),     32'd0);
    chk("rst_shadow", 32'(shadow_q),    32'd0);
    chk("rst_busy",   32'(busy),        32'd0);
    chk("rst_grant",  32'(grant_id),    32'd0);
  endtask

  task automatic new_cmd(input int r);
    int       p;
    bit [2:0] sel;
    bit [7:0] data;
    p    = $urandom_range(0, 99);
    sel  = 3'($urandom_range(0, 7));
    data = 8'($urandom);
    if ($urandom_range(0, 3) == 0) data = m_shadow;
    if ($urandom_range(0, 3) == 0) data[0] = m_shadow[sel];
    req_valid[r]        = 1'b1;
    req_op[2*r +: 2]    = (p < 10) ? 2'b00 : (p < 45) ? 2'b01 : (p < 88) ? 2'b10 : 2'b11;
    req_sel[3*r +: 3]   = sel;
    req_data[8*r +: 8]  = data;
  endtask

  task automatic drive_stim();
    for (int r = 0; r < N_REQ; r++) begin
      if (acc[r] || !req_valid[r]) begin
        if ($urandom_range(0, 1) == 1) new_cmd(r);
        else req_valid[r] = 1'b0;
      end
    end
    acc = '0;
  endtask

  // Compare one cycle of DUT outputs, then advance the reference by one edge.
  task automatic model_step();
    bit             e_en, e_clr, e_busy;
    bit [2:0]       e_s;
    bit             e_d;
    bit [N_REQ-1:0] e_ready;
    int             win;
    int             idx;
    item_t          it;
    bit [1:0]       op;
    bit [2:0]       sel;
    bit [7:0]       data;

    e_en = 1'b1; e_clr = 1'b1; e_busy = 1'b0; e_s = m_s; e_d = m_d;
    if (q.size() > 0) begin
      it     = q[0];
      e_busy = 1'b1;
      if (it.clr) e_clr = 1'b0;
      else begin
        e_en = 1'b0; e_s = it.s; e_d = it.d;
      end
    end
    if (m_rst_clr) e_clr = 1'b0;

    e_ready = '0;
    win     = -1;
    if (q.size() == 0) begin
      for (int k = 1; k <= N_REQ; k++) begin
        idx = (m_last + k) % N_REQ;
        if (win < 0 && req_valid[idx]) win = idx;
      end
    end
    if (win >= 0) e_ready[win] = 1'b1;

    chk("ready",  32'(req_ready),   32'(e_ready));
    chk("en_b",   32'(latch_en_b),  32'(e_en));
    chk("clr_b",  32'(latch_clr_b), 32'(e_clr));
    chk("s",      32'(latch_s),     32'(e_s));
    chk("d",      32'(latch_d),     32'(e_d));
    chk("busy",   32'(busy),        32'(e_busy));
    chk("shadow", 32'(shadow_q),    32'(m_shadow));
    chk("grant",  32'(grant_id),    32'(m_grant));

    if (q.size() > 0) begin
      it = q.pop_front();
      if (it.clr) m_shadow = 8'h00;
      else begin
        m_shadow[it.s] = it.d;
        m_s = it.s;
        m_d = it.d;
      end
    end
    if (m_rst_clr) begin
      m_shadow  = 8'h00;
      m_rst_clr = 1'b0;
    end

    if (win >= 0) begin
      acc[win] = 1'b1;
      m_last   = win;
      m_grant  = win;
      op   = req_op[2*win +: 2];
      sel  = req_sel[3*win +: 3];
      data = req_data[8*win +: 8];
      case (op)
        2'b01: if (data[0] != m_shadow[sel]) q.push_back('{clr: 1'b0, s: sel, d: data[0]});
        2'b10: begin
          for (int b = 0; b < 8; b++)
            if (data[b] != m_shadow[b]) q.push_back('{clr: 1'b0, s: 3'(b), d: data[b]});
        end
        2'b11: q.push_back('{clr: 1'b1, s: 3'd0, d: 1'b0});
        default: ;
      endcase
    end
  endtask

  initial begin
    rst_b     = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_sel   = '0;
    req_data  = '0;
    acc       = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset_vals();
    @(posedge clk);
    #1 rst_b = 1'b1;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk);
        #1;
      end
      // Occasionally abort a multi-strobe command with an asynchronous reset.
      if (q.size() >= 2 && $urandom_range(0, 24) == 0) begin
        rst_b = 1'b0;
        #1;
        chk_reset_vals();
        model_reset();
        @(posedge clk);
        #1 rst_b = 1'b1;
      end
      drive_stim();
      @(negedge clk);
      model_step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
